gshare_dirp: RTL and testbench

Parametrised two-level global-history direction predictor for the fetch stage; successor to the fixed-width global-history predictor. It is indexed by the global history register (BHR), XORed with fetch-PC bits when enabled. Counter width and history length are configurable. It has a registered one-stage PHT update pipeline with prediction forwarding, and misprediction recovery of the BHR from the checkpoint carried with each branch.

---
 rtl/gshare_dirp_pkg.sv | 49 ++++
 rtl/gshare_dirp_sat_ctr_upd.sv | 21 ++
 rtl/gshare_dirp.sv | 167 ++++++++++++++++
 tb/tb_gshare_dirp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gshare_dirp_pkg.sv
// gshare_dirp_pkg: shared definitions for the gshare direction predictor.
//   - BR_STATE_W and the branch-resolution encodings (BR_NONE / BR_PR_CORRECT /
//     BR_PR_WRONG).
//   - Counter-state helpers: weak-not-taken reset value and the saturating
//     increment/decrement step. The helpers work on a CTR_MAX_W-wide container
//     and take the real counter width as an argument, so any CTR_W up to
//     CTR_MAX_W can share them.
package gshare_dirp_pkg;

    localparam int BR_STATE_W = 2;

    typedef enum logic [BR_STATE_W-1:0] {
        BR_NONE       = 2'd0,
        BR_PR_CORRECT = 2'd1,
        BR_PR_WRONG   = 2'd2
    } br_state_e;

    localparam int CTR_MAX_W = 16;

    // Weak-not-taken: 2^(w-1)-1, i.e. just below the taken threshold.
    function automatic logic [CTR_MAX_W-1:0] ctr_weak_nt(input int w);
        return (CTR_MAX_W'(1) << (w - 1)) - CTR_MAX_W'(1);
    endfunction

    // One saturating step of a w-bit counter: +1 capped at 2^w-1 when taken,
    // -1 floored at 0 otherwise. Never wraps.
    function automatic logic [CTR_MAX_W-1:0] ctr_sat_step(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int                   w
    );
        logic [CTR_MAX_W-1:0] max_v;
        max_v = (CTR_MAX_W'(1) << w) - CTR_MAX_W'(1);
        if (taken) begin
            if (ctr >= max_v) begin
                return ctr;
            end else begin
                return ctr + CTR_MAX_W'(1);
            end
        end else begin
            if (ctr == CTR_MAX_W'(0)) begin
                return ctr;
            end else begin
                return ctr - CTR_MAX_W'(1);
            end
        end
    endfunction

endpackage

// File: rtl/gshare_dirp_sat_ctr_upd.sv
// sat_ctr_upd: combinational next value of a CTR_W-bit saturating counter.
// Ports:
//   ctr_i    current counter value
//   taken_i  resolved direction (1 = taken -> count up)
//   ctr_o    saturated next value
module sat_ctr_upd
    import gshare_dirp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_o
);

    // Widen into the helper's container, step, and narrow back.
    always_comb begin
        ctr_o = CTR_W'(ctr_sat_step(CTR_MAX_W'(ctr_i), taken_i, CTR_W));
    end

endmodule

// File: rtl/gshare_dirp.sv
// gshare_dirp: two-level global-history branch direction predictor.
// The PHT (2^BHR_W saturating counters, flop based) is indexed by the global
// history register, optionally XORed with PC[BHR_W+1:2]. Resolved branches
// update the PHT through a one-stage pipeline; the fetch read forwards the
// in-flight updated value on an index match. A misprediction restores the BHR
// from the checkpoint carried with the branch.
//
// Build option: define GSHARE_PC_XOR_EN to fold the PC into both the fetch and
// the resolution index (gshare); leave it undefined for pure GAg indexing, in
// which case pc_i and recrv_pc_i are ignored.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   is_br_i       fetch slot holds a conditional branch
//   pc_i          fetch PC
//   pred_o        predicted direction (1 = taken), combinational
//   save_bhr_o    BHR checkpoint (pre-update) travelling with the branch
//   reslv_i       resolution: BR_NONE / BR_PR_CORRECT / BR_PR_WRONG
//   is_taken_i    actual direction of the resolved branch
//   recrv_bhr_i   checkpoint of the resolved branch
//   recrv_pc_i    PC of the resolved branch
module gshare_dirp
    import gshare_dirp_pkg::*;
#(
    parameter int BHR_W = 8,
    parameter int CTR_W = 2,
    parameter int PC_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_br_i,
    input  logic [PC_W-1:0]       pc_i,
    output logic                  pred_o,
    output logic [BHR_W-1:0]      save_bhr_o,
    input  logic [BR_STATE_W-1:0] reslv_i,
    input  logic                  is_taken_i,
    input  logic [BHR_W-1:0]      recrv_bhr_i,
    input  logic [PC_W-1:0]       recrv_pc_i
);

    localparam int PHT_N = 1 << BHR_W;

    logic [BHR_W-1:0] bhr_q, bhr_d;
    logic             upd_v_q, upd_v_d;
    logic [BHR_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_t_q, upd_t_d;
    logic [CTR_W-1:0] pht_q [PHT_N];
    logic [CTR_W-1:0] pht_d [PHT_N];

    logic [BHR_W-1:0] fidx_s;
    logic [BHR_W-1:0] ridx_s;
    logic [CTR_W-1:0] upd_rd_s;
    logic [CTR_W-1:0] upd_wr_s;
    logic [CTR_W-1:0] fetch_rd_s;
    logic [CTR_W-1:0] fwd_ctr_s;
    logic [CTR_W-1:0] eff_ctr_s;
    logic             pred_s;
    logic             unused_pc_s;

    // PC bits outside the index slice (or all of them in GAg mode) are not needed.
    assign unused_pc_s = ^{pc_i, recrv_pc_i};

    // Fetch and resolution indices.
    always_comb begin
`ifdef GSHARE_PC_XOR_EN
        fidx_s = bhr_q ^ pc_i[BHR_W+1:2];
        ridx_s = recrv_bhr_i ^ recrv_pc_i[BHR_W+1:2];
`else
        fidx_s = bhr_q;
        ridx_s = recrv_bhr_i;
`endif
    end

    // Two PHT read ports: one for fetch, one for the update stage.
    assign fetch_rd_s = pht_q[fidx_s];
    assign upd_rd_s   = pht_q[upd_idx_q];

    // Write path: post-update value of the entry held in the update stage.
    sat_ctr_upd #(.CTR_W(CTR_W)) u_wr_upd (
        .ctr_i   (upd_rd_s),
        .taken_i (upd_t_q),
        .ctr_o   (upd_wr_s)
    );

    // Forward path: stepped from the fetch read; only used when the fetch
    // index equals the update index, where both reads see the same entry.
    sat_ctr_upd #(.CTR_W(CTR_W)) u_fwd_upd (
        .ctr_i   (fetch_rd_s),
        .taken_i (upd_t_q),
        .ctr_o   (fwd_ctr_s)
    );

    // Effective counter seen by fetch, including forwarding of the pending write.
    always_comb begin
        if (upd_v_q && (upd_idx_q == fidx_s)) begin
            eff_ctr_s = fwd_ctr_s;
        end else begin
            eff_ctr_s = fetch_rd_s;
        end
    end

    assign pred_s = eff_ctr_s[CTR_W-1];

    // Outputs are forced to zero while reset is asserted, since the PHT is
    // only cleared at the reset edge.
    always_comb begin
        if (rst) begin
            pred_o     = 1'b0;
            save_bhr_o = '0;
        end else begin
            pred_o     = pred_s;
            save_bhr_o = bhr_q;
        end
    end

    // Next BHR and update-stage capture; recovery outranks a fetch branch.
    always_comb begin
        bhr_d     = bhr_q;
        upd_v_d   = 1'b0;
        upd_idx_d = upd_idx_q;
        upd_t_d   = upd_t_q;
        if (rst) begin
            bhr_d   = '0;
            upd_v_d = 1'b0;
        end else begin
            if (reslv_i == BR_PR_WRONG) begin
                bhr_d = {recrv_bhr_i[BHR_W-2:0], is_taken_i};
            end else if (is_br_i) begin
                bhr_d = {bhr_q[BHR_W-2:0], pred_s};
            end else begin
                bhr_d = bhr_q;
            end
            if (reslv_i != BR_NONE) begin
                upd_v_d   = 1'b1;
                upd_idx_d = ridx_s;
                upd_t_d   = is_taken_i;
            end else begin
                upd_v_d   = 1'b0;
            end
        end
    end

    // PHT next state: reset fills every entry with weak-not-taken, which also
    // drops any update still pending in the stage.
    always_comb begin
        pht_d = pht_q;
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_d[i] = CTR_W'(ctr_weak_nt(CTR_W));
            end
        end else if (upd_v_q) begin
            pht_d[upd_idx_q] = upd_wr_s;
        end else begin
            pht_d = pht_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        bhr_q     <= bhr_d;
        upd_v_q   <= upd_v_d;
        upd_idx_q <= upd_idx_d;
        upd_t_q   <= upd_t_d;
        pht_q     <= pht_d;
    end

endmodule

// File: tb/tb_gshare_dirp.sv
// tb_gshare_dirp: directed + random self-checking bench for gshare_dirp.
// A reference model keeps the architectural PHT/BHR (an update is applied as
// soon as the resolution is accepted, which is what forwarding must make
// visible); expected outputs are queued when each step is driven and compared
// on the falling edge.
module tb_gshare_dirp;
    import gshare_dirp_pkg::*;

    localparam int BHR_W = 8;
    localparam int CTR_W = 2;
    localparam int PC_W  = 64;
    localparam int N     = 1 << BHR_W;
`ifdef GSHARE_PC_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  is_br_i;
    logic [PC_W-1:0]       pc_i;
    logic                  pred_o;
    logic [BHR_W-1:0]      save_bhr_o;
    logic [BR_STATE_W-1:0] reslv_i;
    logic                  is_taken_i;
    logic [BHR_W-1:0]      recrv_bhr_i;
    logic [PC_W-1:0]       recrv_pc_i;

    gshare_dirp #(.BHR_W(BHR_W), .CTR_W(CTR_W), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .is_br_i     (is_br_i),
        .pc_i        (pc_i),
        .pred_o      (pred_o),
        .save_bhr_o  (save_bhr_o),
        .reslv_i     (reslv_i),
        .is_taken_i  (is_taken_i),
        .recrv_bhr_i (recrv_bhr_i),
        .recrv_pc_i  (recrv_pc_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pred;
        logic [7:0] save;
    } exp_t;

    exp_t       sb_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [1:0] m_pht [N];
    logic [7:0] m_bhr = 8'h00;
    logic       m_pred;

    function automatic logic [7:0] tb_idx(input logic [7:0] h, input logic [7:0] pcb);
        return XOR_EN ? (h ^ pcb) : h;
    endfunction

    task automatic drive(input logic r, input logic br, input logic [63:0] pc,
                         input logic [1:0] rs, input logic tk,
                         input logic [7:0] rb, input logic [63:0] rpc);
        rst         = r;
        is_br_i     = br;
        pc_i        = pc;
        reslv_i     = rs;
        is_taken_i  = tk;
        recrv_bhr_i = rb;
        recrv_pc_i  = rpc;
    endtask

    // One cycle: queue expectation, check on negedge, advance model at posedge.
    task automatic step(input string tag);
        exp_t       e;
        logic [7:0] ri;
        if (rst) begin
            m_pred = 1'b0;
            e      = '{pred: 1'b0, save: 8'h00};
        end else begin
            m_pred = m_pht[tb_idx(m_bhr, pc_i[9:2])][1];
            e      = '{pred: m_pred, save: m_bhr};
        end
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        tests_run++;
        assert (pred_o === e.pred) else begin
            tests_failed++;
            $error("FAIL %s pred_o observed=%0b expected=%0b", tag, pred_o, e.pred);
        end
        tests_run++;
        assert (save_bhr_o === e.save) else begin
            tests_failed++;
            $error("FAIL %s save_bhr_o observed=%02h expected=%02h", tag, save_bhr_o, e.save);
        end
        @(posedge clk);
        if (rst) begin
            m_bhr = 8'h00;
            for (int i = 0; i < N; i++) m_pht[i] = 2'b01;
        end else begin
            if (reslv_i == BR_PR_WRONG) m_bhr = {recrv_bhr_i[6:0], is_taken_i};
            else if (is_br_i)           m_bhr = {m_bhr[6:0], m_pred};
            if (reslv_i != BR_NONE) begin
                ri = tb_idx(recrv_bhr_i, recrv_pc_i[9:2]);
                if (is_taken_i && m_pht[ri] != 2'b11)       m_pht[ri] = m_pht[ri] + 2'b01;
                else if (!is_taken_i && m_pht[ri] != 2'b00) m_pht[ri] = m_pht[ri] - 2'b01;
            end
        end
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b1, 64'h1000, BR_NONE, 1'b0, 8'h00, 64'h0);
        @(posedge clk);
        #1;
        step("reset0");
        step("reset1");

        // Reset release: first fetch branch predicts NT, BHR stays 0.
        drive(1'b0, 1'b1, 64'h1000, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("first_fetch");
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("bhr_after_fetch");

        // Set BHR=0x05, then four taken resolutions on index 0x05.
        drive(1'b0, 1'b0, 64'h0, BR_PR_WRONG, 1'b1, 8'h02, 64'h0);
        step("recover_05");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 64'h0, BR_PR_CORRECT, 1'b1, 8'h05, 64'h0);
            step("inc_sat");
        end
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("after_inc");

        // Four not-taken on the saturated entry: 10, 01, 00, 00.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 64'h0, BR_PR_CORRECT, 1'b0, 8'h05, 64'h0);
            step("dec_floor");
        end
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("after_dec");
        // One taken from the floor stays below threshold (00->01), no wrap.
        drive(1'b0, 1'b0, 64'h0, BR_PR_CORRECT, 1'b1, 8'h05, 64'h0);
        step("floor_inc");
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("floor_chk");

        // BHR=0xAA, then recovery racing a fetch branch -> 0x79.
        drive(1'b0, 1'b0, 64'h0, BR_PR_WRONG, 1'b0, 8'h55, 64'h0);
        step("set_aa");
        drive(1'b0, 1'b1, 64'h0, BR_PR_WRONG, 1'b1, 8'h3C, 64'h0);
        step("recover_race");
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("bhr_79");

        // Resolution latched, reset next cycle: the pending write is dropped.
        drive(1'b0, 1'b0, 64'h0, BR_PR_CORRECT, 1'b1, 8'h33, 64'h0);
        step("late_res");
        drive(1'b1, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("late_rst");
        drive(1'b0, 1'b0, 64'h0, BR_PR_WRONG, 1'b1, 8'h19, 64'h0);
        step("set_33");
        drive(1'b0, 1'b0, 64'h0, BR_PR_CORRECT, 1'b1, 8'h33, 64'h0);
        step("no_late_write");
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("after_late");

        // Train 0x12 taken, BHR=0x12, fetch at several PCs.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 64'h0, BR_PR_CORRECT, 1'b1, 8'h12, 64'h0);
            step("train_12");
        end
        drive(1'b0, 1'b0, 64'h0, BR_PR_WRONG, 1'b0, 8'h09, 64'h0);
        step("set_12");
        drive(1'b0, 1'b0, 64'hFFC, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("pc_ffc");
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("pc_000");
        drive(1'b0, 1'b1, 64'hFFC, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("pc_ffc_br");
        drive(1'b0, 1'b0, 64'h0, BR_NONE, 1'b0, 8'h00, 64'h0);
        step("bhr_shift");

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  {32'h0, 28'h0, 4'($urandom_range(0, 15))});
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
